tick_uart_tx: RTL and testbench
===============================

Name: tick_uart_tx

Overview:
Tick-paced serial transmitter that sits directly downstream of the periodic pulse/tick divider. It consumes the divider's one-cycle strobe as the bit-period boundary. It accepts parallel words on a valid/ready handshake and shifts out an asynchronous serial frame: start bit, LSB-first data, optional parity, then stop bit(s).

Parameters:
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY_EN, 0: 1 appends a parity bit after the data bits.
- PARITY_ODD, 0: with PARITY_EN=1, 0 selects even parity and 1 selects odd parity.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- tick  in  1  bit-period strobe from the upstream divider; every cycle with tick=1 is one bit boundary
- in_valid  in  1  in_data holds a word to send
- in_data  in  DATA_BITS  word to send; bit 0 is transmitted first
- in_ready  out  1  block can accept a word; high only in IDLE
- tx  out  1  serial line, registered, idles high
- busy  out  1  high whenever state != IDLE
- frame_done  out  1  one-cycle pulse when the final stop bit completes

Behaviour:
- Reset values (all outputs): state=IDLE, tx=1, busy=0, frame_done=0, in_ready=1. Internal shift register, bit index and stop counter clear to 0.
- Reset has priority over every other input.
- Reset mid-frame:
  - The next edge forces IDLE with tx=1.
  - The frame in progress is discarded and no frame_done is generated.
- Accept: a word is taken at a posedge where in_valid & in_ready.
  - The block latches in_data into the shift register and computes the parity bit (XOR of the data bits, inverted when PARITY_ODD=1).
  - The state moves to SYNC.
  - A tick in the accept cycle is ignored.
- in_data and in_valid are ignored while busy.
- States and transitions (all advances occur only on a cycle with tick=1; tx is registered and changes on the edge that ends the tick cycle):
  - IDLE: tx=1. Accept -> SYNC.
  - SYNC: tx=1. tick -> START, tx<=0.
  - START: tick -> DATA, tx<=shift[0], bit index=0.
  - DATA: tick with bit index < DATA_BITS-1 -> shift right, tx<=next bit, bit index+1.
  - DATA: tick with bit index = DATA_BITS-1 -> PARITY with tx<=parity if PARITY_EN=1; otherwise -> STOP with tx<=1 and stop counter=0.
  - PARITY: tick -> STOP, tx<=1, stop counter=0.
  - STOP: tick with stop counter < STOP_BITS-1 -> stop counter+1.
  - STOP: tick with stop counter = STOP_BITS-1 -> IDLE; frame_done=1 for exactly that next cycle.
- Bit timing: each serial bit is held for exactly one tick period. A tick held continuously high gives 1-cycle bits.
- Latency from accept to tx falling edge = cycles until the first tick after accept, plus 1.
- Back-to-back words:
  - in_ready reasserts in the cycle frame_done is high.
  - A word accepted then follows SYNC rules; there is no gap beyond SYNC.
- Combinational outputs:
  - in_ready = (state==IDLE).
  - busy = !in_ready.
- All other outputs are registered.
- Bit index width is clog2(DATA_BITS). Counters never wrap because states bound them.

Test Plan:
- Default parameters, upstream divider max=3 with enable held high (tick every 4 cycles), send 0xA5:
  - tx after SYNC = 0, 1,0,1,0,0,1,0,1, 1, each level held 4 cycles.
  - frame_done pulses once; busy spans the whole frame; in_ready=0 throughout.
- PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1. Repeat with PARITY_ODD=1 -> parity bit 0. Check the frame is 11 bit-periods long.
- STOP_BITS=2, send 0xFF -> stop level high for 8 cycles before frame_done; no extra cycle.
- in_valid held high with 0x00 then 0xFF:
  - Second word accepted in the cycle frame_done=1.
  - Second frame's start bit begins after the next tick.
  - in_data changes while busy do not corrupt the first frame.
- rst asserted during data bit 3:
  - Next cycle tx=1, busy=0, in_ready=1.
  - No frame_done.
  - A following 0x3C transmits correctly.
- Upstream divider max=0 (tick constantly high), send 0x81:
  - Each bit lasts 1 cycle.
  - Accept-to-start-bit latency = 2 cycles.
  - Full frame = 10 cycles after SYNC.

Source files
------------

// File: rtl/tick_uart_tx.sv
// Tick-paced UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Latency: first tx edge one cycle after the first tick following accept; one bit per tick period.
// Backpressure: in_ready only in IDLE; words are taken on in_valid & in_ready, ignored while busy.
module tick_uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic ODD_SEL   = (PARITY_ODD != 0);
    localparam logic PAR_ON    = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 tx_q, tx_d;
    logic                 frame_done_q, frame_done_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 parity_q, parity_d;

    always_comb begin
        state_d      = state_q;
        tx_d         = tx_q;
        frame_done_d = 1'b0;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        stop_cnt_d   = stop_cnt_q;
        parity_d     = parity_q;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                // The accept cycle never consumes a tick; SYNC waits for the next one.
                if (in_valid) begin
                    shift_d  = in_data;
                    parity_d = (^in_data) ^ ODD_SEL;
                    state_d  = S_SYNC;
                end
            end
            S_SYNC: begin
                tx_d = 1'b1;
                if (tick) begin
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d   = S_DATA;
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_idx_q != LAST_IDX) begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 1'b1;
                    end else if (PAR_ON) begin
                        state_d = S_PARITY;
                        tx_d    = parity_q;
                    end else begin
                        state_d    = S_STOP;
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d    = S_STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (stop_cnt_q != STOP_LAST) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d      = S_IDLE;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tx_q         <= 1'b1;
            frame_done_q <= 1'b0;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            stop_cnt_q   <= 1'b0;
            parity_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_q         <= tx_d;
            frame_done_q <= frame_done_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            stop_cnt_q   <= stop_cnt_d;
            parity_q     <= parity_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = !in_ready;
    assign tx         = tx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_tick_uart_tx.sv
// Directed bench for tick_uart_tx: four parameterisations share clk/rst/tick/in_* and are checked cycle by cycle.
module tb_tick_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       in_valid;
    logic [7:0] in_data;
    logic [3:0] tx_v, busy_v, rdy_v, done_v;

    int vectors     = 0;
    int miscompares = 0;
    int tick_max    = 3;
    int tick_cnt    = 0;

    // Expected frame per instance, bit 0 = start bit, sent first.
    logic [11:0] exp_f [4];
    int          exp_l [4];

    always #5 clk = ~clk;

    tick_uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_def (
        .clk(clk), .rst(rst), .tick(tick), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .frame_done(done_v[0]));
    tick_uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_pe (
        .clk(clk), .rst(rst), .tick(tick), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .frame_done(done_v[1]));
    tick_uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_po (
        .clk(clk), .rst(rst), .tick(tick), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .frame_done(done_v[2]));
    tick_uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_s2 (
        .clk(clk), .rst(rst), .tick(tick), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .frame_done(done_v[3]));

    // Advance one cycle and emulate the upstream divider (tick when count hits tick_max).
    task automatic step();
        @(posedge clk);
        #1;
        tick_cnt = (tick_cnt == tick_max) ? 0 : tick_cnt + 1;
        tick     = (tick_cnt == tick_max);
    endtask

    task automatic chk(input string tag, input int k, input int t,
                       input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d t=%0d observed=%0h expected=%0h", tag, k, t, obs, exp);
        end
    endtask

    task automatic align();
        for (int i = 0; i < 200; i++) begin
            if (busy_v == 4'b0000 && tick_cnt == 0) break;
            step();
        end
        chk("align_idle", 0, 0, 16'(busy_v), 16'h0000);
    endtask

    // Offer word in the current cycle (tick count 0) and check every masked instance each cycle.
    task automatic frame_run(input logic [7:0] word, input logic [7:0] next_data,
                             input bit hold_valid, input logic [3:0] mask);
        int   p, s, e, tmax;
        logic exp_tx;
        p    = tick_max + 1;
        s    = (p == 1) ? 2 : p;
        tmax = 0;
        for (int k = 0; k < 4; k++)
            if (mask[k] && (s + p * exp_l[k]) > tmax) tmax = s + p * exp_l[k];
        in_data  = word;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++)
            if (mask[k]) chk("accept_rdy", k, 0, 16'(rdy_v[k]), 16'h0001);
        for (int t = 1; t <= tmax; t++) begin
            step();
            if (t == 1) begin
                in_data = next_data;
                if (!hold_valid) in_valid = 1'b0;
            end
            for (int k = 0; k < 4; k++) begin
                e = s + p * exp_l[k];
                if (mask[k] && t <= e) begin
                    exp_tx = (t < s || t == e) ? 1'b1 : exp_f[k][(t - s) / p];
                    chk("tx",         k, t, 16'(tx_v[k]),   16'(exp_tx));
                    chk("busy",       k, t, 16'(busy_v[k]), 16'(t < e));
                    chk("in_ready",   k, t, 16'(rdy_v[k]),  16'(t >= e));
                    chk("frame_done", k, t, 16'(done_v[k]), 16'(t == e));
                end
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        tick_max = 3;
        tick_cnt = 0;
        tick     = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            chk("rst_tx",   k, 0, 16'(tx_v[k]),   16'h0001);
            chk("rst_busy", k, 0, 16'(busy_v[k]), 16'h0000);
            chk("rst_rdy",  k, 0, 16'(rdy_v[k]),  16'h0001);
            chk("rst_done", k, 0, 16'(done_v[k]), 16'h0000);
        end
        rst = 1'b0;
        align();

        // 0xA5: four ones -> even parity 0, odd parity 1.
        exp_f[0] = {2'b00, 1'b1, 8'hA5, 1'b0};        exp_l[0] = 10;
        exp_f[1] = {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};   exp_l[1] = 11;
        exp_f[2] = {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0};   exp_l[2] = 11;
        exp_f[3] = {1'b0, 2'b11, 8'hA5, 1'b0};        exp_l[3] = 11;
        frame_run(8'hA5, 8'h00, 1'b0, 4'b1111);
        align();

        // 0x07: three ones -> even parity 1, odd parity 0.
        exp_f[0] = {2'b00, 1'b1, 8'h07, 1'b0};
        exp_f[1] = {1'b0, 1'b1, 1'b1, 8'h07, 1'b0};
        exp_f[2] = {1'b0, 1'b1, 1'b0, 8'h07, 1'b0};
        exp_f[3] = {1'b0, 2'b11, 8'h07, 1'b0};
        frame_run(8'h07, 8'h00, 1'b0, 4'b1111);
        align();

        // 0xFF: eight ones -> even 0, odd 1; two-stop instance holds high 8 cycles.
        exp_f[0] = {2'b00, 1'b1, 8'hFF, 1'b0};
        exp_f[1] = {1'b0, 1'b1, 1'b0, 8'hFF, 1'b0};
        exp_f[2] = {1'b0, 1'b1, 1'b1, 8'hFF, 1'b0};
        exp_f[3] = {1'b0, 2'b11, 8'hFF, 1'b0};
        frame_run(8'hFF, 8'h00, 1'b0, 4'b1111);
        align();

        // Back-to-back on the default instance: valid held, data changes while busy.
        exp_f[0] = {2'b00, 1'b1, 8'h00, 1'b0};
        frame_run(8'h00, 8'hFF, 1'b1, 4'b0001);
        exp_f[0] = {2'b00, 1'b1, 8'hFF, 1'b0};
        frame_run(8'hFF, 8'h00, 1'b0, 4'b0001);
        align();

        // Reset during data bit 3 (cycles 20..23 after accept; bit 3 of 0xA5 is 0).
        in_data  = 8'hA5;
        in_valid = 1'b1;
        for (int t = 1; t <= 21; t++) begin
            step();
            if (t == 1) in_valid = 1'b0;
        end
        chk("bit3_tx", 0, 21, 16'(tx_v[0]), 16'h0000);
        rst = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            chk("midrst_tx",   k, 22, 16'(tx_v[k]),   16'h0001);
            chk("midrst_busy", k, 22, 16'(busy_v[k]), 16'h0000);
            chk("midrst_rdy",  k, 22, 16'(rdy_v[k]),  16'h0001);
        end
        rst = 1'b0;
        for (int t = 23; t < 83; t++) begin
            step();
            chk("postrst_done", 0, t, 16'(done_v), 16'h0000);
            chk("postrst_tx",   0, t, 16'(tx_v),   16'h000F);
        end
        align();

        // 0x3C: four ones -> even 0, odd 1.
        exp_f[0] = {2'b00, 1'b1, 8'h3C, 1'b0};
        exp_f[1] = {1'b0, 1'b1, 1'b0, 8'h3C, 1'b0};
        exp_f[2] = {1'b0, 1'b1, 1'b1, 8'h3C, 1'b0};
        exp_f[3] = {1'b0, 2'b11, 8'h3C, 1'b0};
        frame_run(8'h3C, 8'h00, 1'b0, 4'b1111);
        align();

        // Tick constantly high: 1-cycle bits, start bit 2 cycles after accept.
        tick_max = 0;
        tick_cnt = 0;
        tick     = 1'b1;
        exp_f[0] = {2'b00, 1'b1, 8'h81, 1'b0};
        exp_f[1] = {1'b0, 1'b1, 1'b0, 8'h81, 1'b0};
        exp_f[2] = {1'b0, 1'b1, 1'b1, 8'h81, 1'b0};
        exp_f[3] = {1'b0, 2'b11, 8'h81, 1'b0};
        frame_run(8'h81, 8'h00, 1'b0, 4'b1111);
        align();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
